// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - MEM->WB pipeline register with stall/flush, forwarding and perf counters
module mem_wb_pipe #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 1,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 4,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*ADDR_W-1:0] mem_wd,
    input  logic [NUM_CH-1:0]        mem_wreg,
    input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     flush,
    input  logic [ADDR_W-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [NUM_CH*ADDR_W-1:0] wb_wd,
    output logic [NUM_CH-1:0]        wb_wreg,
    output logic [NUM_CH*DATA_W-1:0] wb_wdata,
    output logic [CNT_W-1:0]         bubble_cnt,
    output logic [CNT_W-1:0]         hold_cnt
);

    localparam logic [NUM_CH*ADDR_W-1:0] NOP_WD    = '0;
    localparam logic [NUM_CH-1:0]        WR_DIS    = '0;
    localparam logic [NUM_CH*DATA_W-1:0] ZERO_DATA = '0;
    localparam logic [CNT_W-1:0]         CNT_MAX   = '1;

    logic [NUM_CH*ADDR_W-1:0] st_wd    [DEPTH];
    logic [NUM_CH-1:0]        st_wreg  [DEPTH];
    logic [NUM_CH*DATA_W-1:0] st_wdata [DEPTH];

    logic stall_self;
    logic stall_next;

    assign stall_self = stall[STAGE_IDX];
    assign stall_next = stall[STAGE_IDX+1];

    // A stalled stage with a running successor must emit a bubble, otherwise
    // the entry it still holds would be written back twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                st_wd[k]    <= NOP_WD;
                st_wreg[k]  <= WR_DIS;
                st_wdata[k] <= ZERO_DATA;
            end
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                st_wd[k]    <= NOP_WD;
                st_wreg[k]  <= WR_DIS;
                st_wdata[k] <= ZERO_DATA;
            end
        end else if (!stall_self) begin
            st_wd[0]    <= mem_wd;
            st_wreg[0]  <= mem_wreg;
            st_wdata[0] <= mem_wdata;
            for (int k = 1; k < DEPTH; k++) begin
                st_wd[k]    <= st_wd[k-1];
                st_wreg[k]  <= st_wreg[k-1];
                st_wdata[k] <= st_wdata[k-1];
            end
        end else if (!stall_next) begin
            st_wd[0]    <= NOP_WD;
            st_wreg[0]  <= WR_DIS;
            st_wdata[0] <= ZERO_DATA;
            for (int k = 1; k < DEPTH; k++) begin
                st_wd[k]    <= st_wd[k-1];
                st_wreg[k]  <= st_wreg[k-1];
                st_wdata[k] <= st_wdata[k-1];
            end
            if (bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end else begin
            if (hold_cnt != CNT_MAX) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end

    assign wb_wd    = st_wd[DEPTH-1];
    assign wb_wreg  = st_wreg[DEPTH-1];
    assign wb_wdata = st_wdata[DEPTH-1];

    // Scan oldest->youngest and high->low channel so the last match written
    // is the youngest stage, lowest channel.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (fwd_addr != '0 && st_wreg[k][c] &&
                    st_wd[k][c*ADDR_W +: ADDR_W] == fwd_addr) begin
                    fwd_hit  = 1'b1;
                    fwd_data = st_wdata[k][c*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule
